cpu_run_ctrl: RTL

- Run/halt/single-step controller for the board-level CPU.
- Debounces two active-low pushbuttons (step, run/halt toggle) and runs a small FSM.
- Drives a clock-enable `cpu_en` into the CPU, so the core advances one cycle per step press or free-runs.
- Also accepts a halt request from the core (e.g. break instruction) and exposes state for the seven-segment display path.

---
 rtl/cpu_run_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: debounced run/halt/single-step controller driving the CPU clock enable.
// Define CPU_RUN_CTRL_STEPCNT_EN to count enabled CPU cycles on step_count.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int CNT_W           = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_step_n,
  input  logic        key_run_n,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic        running,
  output logic [1:0]  ctrl_state,
  output logic [15:0] step_count
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {HALT = 2'b00, STEP = 2'b01, RUN = 2'b10} state_t;
  logic [1:0]       w_key;
  logic [1:0]       r_sync0, r_sync1, r_db, r_press;
  logic [CNT_W-1:0] r_cnt [2];
  logic             w_step_p, w_run_p;
  state_t           r_state, w_next;
  logic             r_cpu_en, r_running;
  assign w_key    = {key_run_n, key_step_n};
  assign w_step_p = r_press[0];
  assign w_run_p  = r_press[1];
  // Bit 0 is the step key, bit 1 the run/halt key; press pulses fire only on debounced falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 2'b11;
      r_sync1 <= 2'b11;
      r_db    <= 2'b11;
      r_press <= 2'b00;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync0 <= w_key;
      r_sync1 <= r_sync0;
      r_press <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (r_sync1[i] == r_db[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == LAST) begin
          r_db[i]    <= r_sync1[i];
          r_cnt[i]   <= '0;
          r_press[i] <= ~r_sync1[i];
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end
  always_comb begin
    w_next = (r_state == HALT) ? ((w_run_p && !halt_req) ? RUN : (w_step_p ? STEP : HALT)) :
             (r_state == RUN)  ? ((halt_req || w_run_p) ? HALT : RUN) : HALT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= HALT;
      r_cpu_en  <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cpu_en  <= (w_next != HALT);
      r_running <= (w_next == RUN);
    end
  end
  assign cpu_en     = r_cpu_en;
  assign running    = r_running;
  assign ctrl_state = r_state;
`ifdef CPU_RUN_CTRL_STEPCNT_EN
  logic [15:0] r_step_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_step_count <= 16'h0000;
    else if (r_cpu_en) r_step_count <= r_step_count + 16'h0001;
  end
  assign step_count = r_step_count;
`else
  assign step_count = 16'h0000;
`endif
endmodule
